// File: rtl/uart_json_drive_tx_if.sv
// Command and byte-stream signals of the wheel-command frame generator.
// The slave modport is the generator's view; master is the driving side.
interface uart_json_drive_tx_if #(
   parameter int unsigned SPD_W = 12
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic signed [SPD_W-1:0] left_speed;
   logic signed [SPD_W-1:0] right_speed;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic                    busy;
   logic                    frame_done;

   modport master (
      output cmd_valid, left_speed, right_speed, tx_ready,
      input  cmd_ready, tx_data, tx_valid, busy, frame_done
   );

   modport slave (
      input  cmd_valid, left_speed, right_speed, tx_ready,
      output cmd_ready, tx_data, tx_valid, busy, frame_done
   );
endinterface

// File: rtl/uart_json_drive_tx.sv
// Formats signed wheel speeds as {"T":t,"L":l,"R":r}\n for uart_tx and re-sends
// the last frame as a heartbeat after RESEND_CYCLES idle clocks.
module uart_json_drive_tx #(
   parameter int unsigned SPD_W         = 12,
   parameter int unsigned FRAC_DIGITS   = 2,
   parameter int unsigned CMD_TYPE      = 1,
   parameter int unsigned RESEND_CYCLES = 5_000_000
) (
   input logic                 clk,
   input logic                 rst,
   uart_json_drive_tx_if.slave bus
);
   localparam int          FD    = int'(FRAC_DIGITS);
   localparam int          LIM   = 10 ** FD;
   localparam int unsigned MAG_W = $clog2(LIM + 1);
   localparam int unsigned BCD_W = 4 * (FRAC_DIGITS + 1);
   localparam int unsigned CNT_W = $clog2(MAG_W);

   typedef enum logic [1:0] {StIdle, StConvert, StSend} state_e;
   typedef enum logic [2:0] {
      SegHead, SegType, SegSign, SegInt, SegDot, SegFrac, SegClose, SegNl
   } seg_e;

   state_e             state_q, state_d;
   seg_e               seg_q, seg_d;
   logic [1:0]         wheel_q, wheel_d;
   logic [2:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        timer_q, timer_d;
   logic [MAG_W-1:0]   lbin_q, lbin_d, rbin_q, rbin_d;
   logic [BCD_W-1:0]   lbcd_q, lbcd_d, rbcd_q, rbcd_d;
   logic [1:0]         neg_q, neg_d;

   logic [BCD_W-1:0]   ladj, radj, cur_bcd;
   logic [MAG_W:0]     lclamp, rclamp;
   logic               cur_neg;
   logic [3:0]         frac_nib;
   logic [7:0]         tx_byte;
   logic               frame_end;
   logic               resend_due;

   // Returns {negative, |clamped value|}, clamped to +-10^FRAC_DIGITS.
   function automatic logic [MAG_W:0] clamp_speed(input logic signed [SPD_W-1:0] v);
      int sv;
      sv = int'(v);
      if (sv >= LIM) return {1'b0, MAG_W'(LIM)};
      if (sv <= -LIM) return {1'b1, MAG_W'(LIM)};
      if (sv < 0) return {1'b1, MAG_W'(-sv)};
      return {1'b0, MAG_W'(sv)};
   endfunction

   // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < FD + 1; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign lclamp     = clamp_speed(bus.left_speed);
   assign rclamp     = clamp_speed(bus.right_speed);
   assign ladj       = dd_adjust(lbcd_q);
   assign radj       = dd_adjust(rbcd_q);
   assign cur_bcd    = (wheel_q == 2'd2) ? rbcd_q : lbcd_q;
   assign cur_neg    = (wheel_q == 2'd2) ? neg_q[1] : neg_q[0];
   assign resend_due = (RESEND_CYCLES != 0) && (timer_q >= RESEND_CYCLES);
   assign frame_end  = (state_q == StSend) && (seg_q == SegNl) && bus.tx_ready;

   always_comb begin
      frac_nib = 4'h0;
      for (int i = 0; i < FD; i++) begin
         if (idx_q == 3'(i)) frac_nib = cur_bcd[4*(FD-1-i) +: 4];
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      if (state_q == StSend) begin
         unique case (seg_q)
            SegHead: begin
               unique case (idx_q)
                  3'd0:       tx_byte = (wheel_q == 2'd0) ? "{" : ",";
                  3'd1, 3'd3: tx_byte = "\"";
                  3'd2:       tx_byte = (wheel_q == 2'd0) ? "T" : ((wheel_q == 2'd1) ? "L" : "R");
                  default:    tx_byte = ":";
               endcase
            end
            SegType:  tx_byte = 8'h30 + 8'(CMD_TYPE);
            SegSign:  tx_byte = "-";
            SegInt:   tx_byte = {4'h3, cur_bcd[BCD_W-1 -: 4]};
            SegDot:   tx_byte = ".";
            SegFrac:  tx_byte = {4'h3, frac_nib};
            SegClose: tx_byte = "}";
            default:  tx_byte = 8'h0A;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      wheel_d = wheel_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      lbin_d  = lbin_q;
      rbin_d  = rbin_q;
      lbcd_d  = lbcd_q;
      rbcd_d  = rbcd_q;
      neg_d   = neg_q;
      unique case (state_q)
         StIdle: begin
            seg_d   = SegHead;
            wheel_d = 2'd0;
            idx_d   = 3'd0;
            // A new command takes priority over a heartbeat falling due this cycle.
            if (bus.cmd_valid) begin
               state_d = StConvert;
               cnt_d   = CNT_W'(MAG_W - 1);
               timer_d = '0;
               neg_d   = {rclamp[MAG_W], lclamp[MAG_W]};
               lbin_d  = lclamp[MAG_W-1:0];
               rbin_d  = rclamp[MAG_W-1:0];
               lbcd_d  = '0;
               rbcd_d  = '0;
            end else if (resend_due) begin
               state_d = StSend;
            end else if (RESEND_CYCLES != 0) begin
               timer_d = timer_q + 32'd1;
            end
         end
         StConvert: begin
            seg_d   = SegHead;
            wheel_d = 2'd0;
            idx_d   = 3'd0;
            lbcd_d  = BCD_W'({ladj, lbin_q[MAG_W-1]});
            rbcd_d  = BCD_W'({radj, rbin_q[MAG_W-1]});
            lbin_d  = lbin_q << 1;
            rbin_d  = rbin_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = StSend;
         end
         StSend: begin
            if (bus.tx_ready) begin
               unique case (seg_q)
                  SegHead: begin
                     if (idx_q == 3'd4) begin
                        idx_d = 3'd0;
                        if (wheel_q == 2'd0) seg_d = SegType;
                        else seg_d = cur_neg ? SegSign : SegInt;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  SegType: begin
                     wheel_d = 2'd1;
                     seg_d   = SegHead;
                  end
                  SegSign: seg_d = SegInt;
                  SegInt:  seg_d = SegDot;
                  SegDot: begin
                     seg_d = SegFrac;
                     idx_d = 3'd0;
                  end
                  SegFrac: begin
                     if (idx_q == 3'(FD - 1)) begin
                        idx_d = 3'd0;
                        if (wheel_q == 2'd1) begin
                           wheel_d = 2'd2;
                           seg_d   = SegHead;
                        end else begin
                           seg_d = SegClose;
                        end
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  SegClose: seg_d = SegNl;
                  default: begin
                     state_d = StIdle;
                     timer_d = '0;
                  end
               endcase
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         seg_q   <= SegHead;
         wheel_q <= 2'd0;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         timer_q <= '0;
         lbin_q  <= '0;
         rbin_q  <= '0;
         lbcd_q  <= '0;
         rbcd_q  <= '0;
         neg_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         wheel_q <= wheel_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         lbin_q  <= lbin_d;
         rbin_q  <= rbin_d;
         lbcd_q  <= lbcd_d;
         rbcd_q  <= rbcd_d;
         neg_q   <= neg_d;
      end
   end

   assign bus.cmd_ready  = (state_q == StIdle);
   assign bus.busy       = (state_q != StIdle);
   assign bus.tx_valid   = (state_q == StSend);
   assign bus.tx_data    = tx_byte;
   assign bus.frame_done = frame_end;
endmodule

// File: tb/tb_uart_json_drive_tx.sv
// Scoreboard bench for uart_json_drive_tx: expected bytes are queued by stimulus
// and popped by a negedge monitor on every accepted byte.
module tb_uart_json_drive_tx;
   localparam int unsigned SPD_W  = 12;
   localparam int          LAT    = SPD_W + 4;
   localparam int          RESEND = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_json_drive_tx_if #(.SPD_W(SPD_W)) bus ();
   uart_json_drive_tx_if #(.SPD_W(SPD_W)) bus0 ();

   uart_json_drive_tx #(
      .SPD_W(SPD_W), .FRAC_DIGITS(2), .CMD_TYPE(1), .RESEND_CYCLES(RESEND)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   uart_json_drive_tx #(
      .SPD_W(SPD_W), .FRAC_DIGITS(2), .CMD_TYPE(1), .RESEND_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_cyc = 0;
   int         bytes_total = 0;
   int         frame_bytes = 0;
   int         frames0 = 0;
   bit         bp_mode = 1'b0;
   logic [7:0] exp_q[$];
   int         len_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push_frame(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      len_q.push_back(s.len());
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) fail("cmd_ready timeout", 32'(bus.cmd_ready), 1);
   endtask

   // Called on the first negedge after the acceptance edge.
   task automatic wait_first_byte();
      int n;
      n = 1;
      while (!bus.tx_valid && n < LAT) begin
         @(negedge clk);
         n++;
      end
      check("first byte latency", 32'(bus.tx_valid), 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail("drain timeout", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic send_cmd(input int l, input int r, input string s);
      push_frame(s);
      bus.left_speed  = SPD_W'(l);
      bus.right_speed = SPD_W'(r);
      bus.cmd_valid   = 1'b1;
      wait_ready();
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_first_byte();
   endtask

   task automatic wait_tx_valid(input int limit);
      int n;
      n = 0;
      while (!bus.tx_valid && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!bus.tx_valid) fail("frame start timeout", 32'(bus.tx_valid), 1);
   endtask

   // tx_ready changes just after each rising edge: always 1, or ~30% duty under backpressure.
   initial begin
      bus.tx_ready  = 1'b1;
      bus0.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit         stall_pend;
      logic [7:0] stall_byte;
      stall_pend = 1'b0;
      stall_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (bus0.frame_done) frames0++;
         if (rst) begin
            frame_bytes = 0;
            stall_pend  = 1'b0;
         end else begin
            if (stall_pend) begin
               check("stalled tx_valid held", 32'(bus.tx_valid), 1);
               check("stalled tx_data held", 32'(bus.tx_data), 32'(stall_byte));
            end
            stall_pend = bus.tx_valid && !bus.tx_ready;
            stall_byte = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
               bytes_total++;
               frame_bytes++;
               if (exp_q.size() == 0) fail("unexpected byte", 32'(bus.tx_data), 0);
               else check("frame byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
               check("frame_done on newline", 32'(bus.frame_done), 32'(bus.tx_data == 8'h0A));
               if (bus.frame_done) begin
                  done_cyc = cyc;
                  if (len_q.size() == 0) fail("unexpected frame end", frame_bytes, 0);
                  else check("frame length", frame_bytes, len_q.pop_front());
                  frame_bytes = 0;
               end
            end else if (bus.frame_done) begin
               fail("frame_done without handshake", 32'(bus.frame_done), 0);
            end
         end
      end
   end

   initial begin
      int n, b0, rel;
      bus.cmd_valid    = 1'b0;
      bus.left_speed   = '0;
      bus.right_speed  = '0;
      bus0.cmd_valid   = 1'b0;
      bus0.left_speed  = '0;
      bus0.right_speed = '0;

      repeat (2) @(negedge clk);
      check("reset cmd_ready", 32'(bus.cmd_ready), 1);
      check("reset tx_valid", 32'(bus.tx_valid), 0);
      check("reset tx_data", 32'(bus.tx_data), 0);
      check("reset busy", 32'(bus.busy), 0);
      check("reset frame_done", 32'(bus.frame_done), 0);
      rst = 1'b0;

      // Single command on the heartbeat-disabled instance.
      bus0.left_speed = SPD_W'(100);
      bus0.cmd_valid  = 1'b1;
      @(negedge clk);
      bus0.cmd_valid  = 1'b0;

      send_cmd(50, 50, "{\"T\":1,\"L\":0.50,\"R\":0.50}\n");
      send_cmd(-7, -2048, "{\"T\":1,\"L\":-0.07,\"R\":-1.00}\n");
      send_cmd(0, -100, "{\"T\":1,\"L\":0.00,\"R\":-1.00}\n");
      bp_mode = 1'b1;
      send_cmd(50, 50, "{\"T\":1,\"L\":0.50,\"R\":0.50}\n");
      wait_ready();
      bp_mode = 1'b0;

      // Held command: the second one must wait for the end of the first frame.
      push_frame("{\"T\":1,\"L\":0.30,\"R\":-0.40}\n");
      push_frame("{\"T\":1,\"L\":0.10,\"R\":0.20}\n");
      bus.left_speed  = SPD_W'(30);
      bus.right_speed = SPD_W'(-40);
      bus.cmd_valid   = 1'b1;
      wait_ready();
      @(negedge clk);
      bus.left_speed  = SPD_W'(10);
      bus.right_speed = SPD_W'(20);
      n = 0;
      while (!bus.cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("held cmd ready after frame_done", cyc - done_cyc, 1);
      check("first frame fully sent", exp_q.size(), 26);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_first_byte();
      wait_drain();

      // Heartbeat: same frame again, twice.
      for (int h = 0; h < 2; h++) begin
         push_frame("{\"T\":1,\"L\":0.10,\"R\":0.20}\n");
         wait_tx_valid(300);
         check_range("heartbeat start", cyc - done_cyc, RESEND, RESEND + LAT);
         wait_drain();
      end

      // Reset in the middle of a frame.
      b0 = bytes_total;
      send_cmd(123, -5, "{\"T\":1,\"L\":1.00,\"R\":-0.05}\n");
      n = 0;
      while (bytes_total < b0 + 10 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (bytes_total < b0 + 10) fail("byte 10 timeout", bytes_total - b0, 10);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("reset drops tx_valid", 32'(bus.tx_valid), 0);
      check("reset drops busy", 32'(bus.busy), 0);
      exp_q.delete();
      len_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      push_frame("{\"T\":1,\"L\":0.00,\"R\":0.00}\n");
      wait_tx_valid(300);
      check_range("post-reset resend start", cyc - rel, RESEND, RESEND + LAT);
      wait_drain();

      check("all expected bytes seen", exp_q.size(), 0);
      check("frames with heartbeat disabled", frames0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_json_drive_tx.md
# uart_json_drive_tx

Parametrised wheel-command frame generator for the car's serial link to the motor controller. It accepts signed left and right wheel speeds through a valid/ready handshake and formats them as an ASCII JSON line, `{"T":<t>,"L":<l>,"R":<r>}\n`. The line goes out as a byte stream that feeds `uart_tx`. Fractional precision, input width and the resend period are configurable. The last accepted command is re-sent periodically as a heartbeat, and a frame is never truncated or interleaved.

## Interface
- `SPD_W`, 12: width of the signed speed inputs (two's complement).
- `FRAC_DIGITS`, 2: fractional digits emitted per wheel. Legal range 1..3.
- `CMD_TYPE`, 1: value of the T field. Legal range 0..9, emitted as one ASCII digit.
- `RESEND_CYCLES`, 5_000_000: idle clocks before the last frame is re-sent. 0 disables the heartbeat.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  a new command is present.
- `cmd_ready`  out  1  the block can accept a command.
- `left_speed`  in  SPD_W  signed left wheel speed, in units of 10^-FRAC_DIGITS.
- `right_speed`  in  SPD_W  signed right wheel speed, same units.
- `tx_data`  out  8  ASCII byte to `uart_tx`.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  `uart_tx` takes the byte on a cycle where `tx_valid` and `tx_ready` are both high.
- `busy`  out  1  a frame is being converted or sent.
- `frame_done`  out  1  one-cycle pulse on the cycle the final `\n` is accepted.

## Operation
- **Command acceptance**
  - A command is accepted on a clock edge where `cmd_valid` and `cmd_ready` are both high.
  - On acceptance, `left_speed` and `right_speed` are latched into the stored command.
- **Clamping**
  - Each value is clamped to ±10^FRAC_DIGITS, so full scale is ±1.0. The most negative input clamps to -10^FRAC_DIGITS.
- **Digit conversion**
  - Each clamped magnitude is converted to one integer digit (0 or 1) followed by FRAC_DIGITS fractional digits.
  - Conversion is iterative (subtract or double-dabble). Digits are stored, and a heartbeat resend reuses them without reconverting.
- **Sign**
  - `-` is emitted directly after `:` only when the clamped value is less than 0. Zero never carries a sign.
- **Frame bytes in order**
  - `{"T":`, then `CMD_TYPE` as one digit.
  - `,"L":`, then the optional `-`, integer digit, `.`, fractional digits.
  - `,"R":`, then the optional `-`, integer digit, `.`, fractional digits.
  - `}`, then `\n`.
- **Frame length**
  - Length is 18 + 2·(FRAC_DIGITS+2) + (number of negative wheels).
  - With FRAC_DIGITS=2 this is 26, 27 or 28 bytes.
- **State machine**
  - IDLE → CONVERT on acceptance.
  - IDLE → SEND when the resend timer expires. This path requires RESEND_CYCLES>0.
  - CONVERT → SEND when conversion completes.
  - SEND → IDLE on acceptance of `\n`.
- **Outputs per state**
  - `cmd_ready` is 1 only in IDLE.
  - `busy` is 1 in CONVERT and SEND.
- **Resend timer**
  - The timer counts clocks spent in IDLE.
  - It is cleared by `frame_done`, by a command acceptance, and by reset.
  - It expires when the count reaches RESEND_CYCLES.
- **Simultaneous events**
  - If `cmd_valid` is high in the same IDLE cycle that the timer expires, the command wins: it is accepted, the resend is dropped and the timer is cleared.
- **Commands during a frame**
  - `cmd_valid` asserted during CONVERT or SEND is held off by `cmd_ready`=0. It is never dropped and never spliced into the current frame.

## Timing
- **Reset values**
  - All outputs: `cmd_ready`=1, `tx_valid`=0, `tx_data`=0x00, `busy`=0, `frame_done`=0.
  - Stored command = (0, 0). Resend timer = 0. State = IDLE.
- **Reset mid-frame**
  - `tx_valid` drops asynchronously and the partial frame is abandoned.
  - After reset is released, no resend occurs until RESEND_CYCLES idle clocks have elapsed. The resent frame then carries L=0 and R=0.
- **Latency to first byte**
  - From the acceptance edge, `tx_valid` rises with `{` within SPD_W+4 cycles.
  - Benches check this bound only, never an exact cycle count.
- **Byte handshake**
  - Once `tx_valid` is high, `tx_data` and `tx_valid` hold until the byte is accepted.
  - `tx_valid` never deasserts mid-frame except on reset.
- **Throughput**
  - With `tx_ready` held at 1, bytes advance one per clock. Gaps between bytes come only from `tx_ready`.
- **After the frame**
  - `frame_done` pulses on the cycle `\n` is accepted.
  - `tx_valid` is 0 on the following cycle, and `cmd_ready` is 1 on that same following cycle.

## Test plan
- **Basic frame:** FRAC_DIGITS=2, send L=50, R=50 with `tx_ready`=1 → exactly 26 bytes `{"T":1,"L":0.50,"R":0.50}\n`, and `frame_done` pulses once.
- **Signs and clamping:** send L=-7, R=-2048 → `{"T":1,"L":-0.07,"R":-1.00}\n`, 28 bytes. Send L=0, R=-100 → 27 bytes containing `"R":-1.00`.
- **Backpressure:** drive `tx_ready` with a random 30% duty → byte sequence identical to the basic-frame case, `tx_data` stable whenever it is stalled, and no bytes duplicated or lost.
- **Held command:** hold `cmd_valid` high during the frame with L=10, R=20 → `cmd_ready`=0 throughout. The second command is accepted the cycle after `frame_done`, and the second frame contains `0.10` and `0.20`.
- **Heartbeat:** RESEND_CYCLES=100, one command followed by idle → an identical frame begins 100 to 100+SPD_W+4 cycles after each `frame_done`. Setting RESEND_CYCLES=0 produces no further frames.
- **Reset mid-frame:** assert `rst` at byte 10 → `tx_valid`=0 immediately. After RESEND_CYCLES idle clocks, the frame is `{"T":1,"L":0.00,"R":0.00}\n`.
